// File: rtl/time_set_ctrl.sv
// ============================================================================
// time_set_ctrl -- front-panel time-setting controller.
//
// Lets the user edit a BCD HH:MM time one digit at a time and then writes the
// result back to the time counters one digit per cycle.
//
//   IDLE   : display follows the live time; only tset_en is honoured.
//   EDIT   : edit buffer captured from tset_cur_time; up/down change the
//            selected digit, left/right move the selection, tset_en cancels,
//            tset_confirm commits. tset_hold freezes the counters.
//   COMMIT : four cycles of one-hot load strobes, MIN_0 first, HR_1 last.
//
// Optional feature (macro TSET_TIMEOUT_EN): an edit that sees TIMEOUT
// tset_tick strobes without a button press is cancelled as if tset_en had
// been pressed. With the macro undefined tset_tick is ignored.
//
// Ports
//   tset_clk       in   clock, rising edge
//   tset_rst       in   asynchronous active-high reset
//   tset_en        in   pulse: enter edit / cancel edit
//   tset_up/down   in   pulse: increment / decrement selected digit
//   tset_left/right in  pulse: move selection toward HR_1 / toward MIN_0
//   tset_confirm   in   pulse: commit edit buffer
//   tset_tick      in   1 Hz strobe, timeout timebase
//   tset_cur_time  in   [15:0] live BCD time {HR_1,HR_0,MIN_1,MIN_0}
//   tset_hold      out  counters frozen (EDIT or COMMIT)
//   tset_sel       out  [3:0] one-hot selected digit, 0 outside EDIT
//   tset_disp      out  [15:0] edit buffer, or live time in IDLE
//   tset_load      out  [3:0] one-hot per-digit load strobe
//   tset_load_num  out  [3:0] BCD value for the strobed digit
// ============================================================================
module time_set_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic        tset_clk,
    input  logic        tset_rst,
    input  logic        tset_en,
    input  logic        tset_up,
    input  logic        tset_down,
    input  logic        tset_left,
    input  logic        tset_right,
    input  logic        tset_confirm,
    input  logic        tset_tick,
    input  logic [15:0] tset_cur_time,
    output logic        tset_hold,
    output logic [3:0]  tset_sel,
    output logic [15:0] tset_disp,
    output logic [3:0]  tset_load,
    output logic [3:0]  tset_load_num
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  cnt_q, cnt_d;       // commit digit index, 0 = MIN_0
    logic        timeout_hit;

    // Largest legal value of digit idx; HR_0 depends on the tens of hours.
    function automatic logic [3:0] digit_max(input logic [1:0] idx,
                                             input logic [3:0] hr1);
        case (idx)
            2'd3:    digit_max = 4'd2;
            2'd2:    digit_max = (hr1 == 4'd2) ? 4'd3 : 4'd9;
            2'd1:    digit_max = 4'd5;
            default: digit_max = 4'd9;
        endcase
    endfunction

    // Digit index of the one-hot selection.
    logic [1:0] sel_idx;
    always_comb begin
        sel_idx = 2'd0;
        case (sel_q)
            4'b1000: sel_idx = 2'd3;
            4'b0100: sel_idx = 2'd2;
            4'b0010: sel_idx = 2'd1;
            default: sel_idx = 2'd0;
        endcase
    end

`ifdef TSET_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;

    // The tick that would bring the count to TIMEOUT ends the edit.
    assign timeout_hit = tset_tick && (to_q == TW'(TIMEOUT - 1));

    always_ff @(posedge tset_clk or posedge tset_rst) begin
        if (tset_rst) to_q <= '0;
        else          to_q <= to_d;
    end
`else
    logic unused_tick;
    assign unused_tick = tset_tick ^ (TIMEOUT == 0);
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge tset_clk or posedge tset_rst) begin
        if (tset_rst) begin
            state_q <= IDLE;
            buf_q   <= 16'h0000;
            sel_q   <= 4'b0000;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    logic [3:0] cur_dig, new_dig, dmax;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cur_dig = buf_q[{sel_idx, 2'b00} +: 4];
        dmax    = digit_max(sel_idx, buf_q[15:12]);
        new_dig = cur_dig;
`ifdef TSET_TIMEOUT_EN
        to_d    = to_q;
`endif

        case (state_q)
            IDLE: begin
                if (tset_en) begin
                    state_d = EDIT;
                    buf_d   = tset_cur_time;
                    sel_d   = 4'b1000;
`ifdef TSET_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end

            EDIT: begin
                if (tset_confirm) begin
                    state_d = COMMIT;
                    cnt_d   = 2'd0;
                    sel_d   = 4'b0000;
                end else if (tset_en || timeout_hit) begin
                    state_d = IDLE;
                    sel_d   = 4'b0000;
                end else begin
`ifdef TSET_TIMEOUT_EN
                    if (tset_up || tset_down || tset_left || tset_right)
                        to_d = '0;
                    else if (tset_tick)
                        to_d = to_q + TW'(1);
`endif
                    // Up and down together cancel out; an out-of-range
                    // digit is pulled back into range by either direction.
                    if (tset_up && !tset_down)
                        new_dig = (cur_dig >= dmax) ? 4'd0 : cur_dig + 4'd1;
                    else if (tset_down && !tset_up)
                        new_dig = (cur_dig == 4'd0 || cur_dig > dmax)
                                  ? dmax : cur_dig - 4'd1;
                    buf_d[{sel_idx, 2'b00} +: 4] = new_dig;

                    // 2x hours cannot exceed 23.
                    if (buf_d[15:12] == 4'd2 && buf_d[11:8] > 4'd3)
                        buf_d[11:8] = 4'd3;

                    if (tset_left && !tset_right)
                        sel_d = {sel_q[2:0], sel_q[3]};
                    else if (tset_right && !tset_left)
                        sel_d = {sel_q[0], sel_q[3:1]};
                end
            end

            COMMIT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3)
                    state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                sel_d   = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded from registered state, so reset clears them
    // without waiting for a clock.
    // ------------------------------------------------------------------------
    always_comb begin
        tset_hold     = (state_q != IDLE);
        tset_sel      = (state_q == EDIT) ? sel_q : 4'b0000;
        tset_disp     = (state_q == IDLE) ? tset_cur_time : buf_q;
        tset_load     = 4'b0000;
        tset_load_num = 4'd0;
        if (state_q == COMMIT) begin
            tset_load     = 4'b0001 << cnt_q;
            tset_load_num = buf_q[{cnt_q, 2'b00} +: 4];
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl. Load strobes are checked by a monitor
// against a queue of expected {load, num} pairs filled by the stimulus;
// hold/sel/disp are checked inline. Timeout checks follow TSET_TIMEOUT_EN.
module tb_time_set_ctrl;

    logic        tset_clk = 1'b0;
    logic        tset_rst;
    logic        tset_en, tset_up, tset_down, tset_left, tset_right;
    logic        tset_confirm, tset_tick;
    logic [15:0] tset_cur_time;
    logic        tset_hold;
    logic [3:0]  tset_sel;
    logic [15:0] tset_disp;
    logic [3:0]  tset_load;
    logic [3:0]  tset_load_num;

    typedef struct {
        logic [3:0] load;
        logic [3:0] num;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    time_set_ctrl #(.TIMEOUT(3)) dut (
        .tset_clk      (tset_clk),
        .tset_rst      (tset_rst),
        .tset_en       (tset_en),
        .tset_up       (tset_up),
        .tset_down     (tset_down),
        .tset_left     (tset_left),
        .tset_right    (tset_right),
        .tset_confirm  (tset_confirm),
        .tset_tick     (tset_tick),
        .tset_cur_time (tset_cur_time),
        .tset_hold     (tset_hold),
        .tset_sel      (tset_sel),
        .tset_disp     (tset_disp),
        .tset_load     (tset_load),
        .tset_load_num (tset_load_num)
    );

    always #5 tset_clk = ~tset_clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every load strobe must match the next queued expectation.
    always @(negedge tset_clk) begin
        if (tset_load !== 4'b0000) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_load: got load %b num %0d expected none",
                         tset_load, tset_load_num);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (tset_load !== e.load || tset_load_num !== e.num) begin
                    n_miss++;
                    $display("FAIL load_seq: got load %b num %0d expected load %b num %0d",
                             tset_load, tset_load_num, e.load, e.num);
                end
            end
        end
    end

    task automatic push(input logic [3:0] l, input logic [3:0] n);
        exp_t e;
        e.load = l;
        e.num  = n;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge tset_clk);
        #1;
        tset_en = 0; tset_up = 0; tset_down = 0; tset_left = 0;
        tset_right = 0; tset_confirm = 0; tset_tick = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tset_rst = 1;
        tset_en = 0; tset_up = 0; tset_down = 0; tset_left = 0;
        tset_right = 0; tset_confirm = 0; tset_tick = 0;
        tset_cur_time = 16'h1259;
        steps(2);
        // reset state
        chk("rst_hold", {15'd0, tset_hold}, 16'd0);
        chk("rst_sel",  {12'd0, tset_sel}, 16'd0);
        chk("rst_load", {8'd0, tset_load, tset_load_num}, 16'd0);
        chk("rst_disp", tset_disp, 16'h1259);
        tset_rst = 0;
        step();

        // basic commit of 12:59
        tset_en = 1; step();
        chk("en_hold", {15'd0, tset_hold}, 16'd1);
        chk("en_sel",  {12'd0, tset_sel}, 16'h0008);
        chk("en_disp", tset_disp, 16'h1259);
        push(4'b0001, 4'd9); push(4'b0010, 4'd5);
        push(4'b0100, 4'd2); push(4'b1000, 4'd1);
        tset_confirm = 1; step();
        chk("commit_hold", {15'd0, tset_hold}, 16'd1);
        steps(4);
        chk("commit_done_hold", {15'd0, tset_hold}, 16'd0);

        // HR_1 up clamps HR_0, then wraps
        tset_cur_time = 16'h1900;
        tset_en = 1; step();
        tset_up = 1; step();
        chk("clamp_up", tset_disp, 16'h2300);
        tset_up = 1; step();
        chk("wrap_up", tset_disp, 16'h0300);
        tset_en = 1; step();
        chk("cancel_hold", {15'd0, tset_hold}, 16'd0);
        chk("cancel_sel",  {12'd0, tset_sel}, 16'd0);
        chk("idle_disp", tset_disp, 16'h1900);

        // MIN_1 wrap down, simultaneous presses, selection rotation
        tset_cur_time = 16'h1204;
        tset_en = 1; step();
        tset_right = 1; step();
        tset_right = 1; step();
        chk("sel_min1", {12'd0, tset_sel}, 16'h0002);
        tset_down = 1; step();
        chk("min1_wrap", tset_disp, 16'h1254);
        tset_up = 1; tset_down = 1; step();
        chk("updown_nop", tset_disp, 16'h1254);
        tset_left = 1; tset_right = 1; step();
        chk("lr_nop", {12'd0, tset_sel}, 16'h0002);
        tset_left = 1; step();
        chk("left", {12'd0, tset_sel}, 16'h0004);
        tset_right = 1; step();
        tset_right = 1; step();
        tset_right = 1; step();
        chk("right_wrap", {12'd0, tset_sel}, 16'h0008);
        tset_up = 1; step();
        chk("hr1_up", tset_disp, 16'h2254);
        tset_down = 1; step();
        tset_down = 1; step();
        tset_down = 1; step();
        chk("hr1_down_wrap", tset_disp, 16'h2254);
        tset_right = 1; step();
        tset_up = 1; step();
        chk("hr0_up", tset_disp, 16'h2354);
        tset_up = 1; step();
        chk("hr0_wrap3", tset_disp, 16'h2054);
        // confirm wins over cancel
        push(4'b0001, 4'd4); push(4'b0010, 4'd5);
        push(4'b0100, 4'd0); push(4'b1000, 4'd2);
        tset_confirm = 1; tset_en = 1; step();
        chk("conf_en_hold", {15'd0, tset_hold}, 16'd1);
        steps(4);
        chk("conf_en_done", {15'd0, tset_hold}, 16'd0);

        // IDLE ignores editing buttons
        tset_up = 1; tset_confirm = 1; tset_left = 1; step();
        steps(2);
        chk("idle_ignore_hold", {15'd0, tset_hold}, 16'd0);

        // reset in the second commit cycle
        tset_cur_time = 16'h0817;
        tset_en = 1; step();
        push(4'b0001, 4'd7);
        tset_confirm = 1; step();
        @(negedge tset_clk);
        @(posedge tset_clk);
        #1;
        tset_rst = 1;
        #1;
        chk("abort_load", {8'd0, tset_load, tset_load_num}, 16'd0);
        chk("abort_hold", {15'd0, tset_hold}, 16'd0);
        chk("abort_sel",  {12'd0, tset_sel}, 16'd0);
        steps(2);
        tset_rst = 0;
        steps(6);
        chk("abort_idle_hold", {15'd0, tset_hold}, 16'd0);
        chk("abort_disp", tset_disp, 16'h0817);

`ifdef TSET_TIMEOUT_EN
        tset_en = 1; step();
        tset_tick = 1; step();
        tset_tick = 1; step();
        chk("to_2ticks", {15'd0, tset_hold}, 16'd1);
        tset_tick = 1; step();
        chk("to_cancel_hold", {15'd0, tset_hold}, 16'd0);
        chk("to_cancel_sel", {12'd0, tset_sel}, 16'd0);
        tset_en = 1; step();
        tset_tick = 1; step();
        tset_tick = 1; step();
        tset_up = 1; step();
        tset_tick = 1; step();
        tset_tick = 1; step();
        chk("to_delayed", {15'd0, tset_hold}, 16'd1);
        tset_tick = 1; step();
        chk("to_delayed_cancel", {15'd0, tset_hold}, 16'd0);
`else
        tset_en = 1; step();
        for (int i = 0; i < 5; i++) begin
            tset_tick = 1; step();
        end
        chk("tick_ignored", {15'd0, tset_hold}, 16'd1);
        tset_en = 1; step();
        chk("tick_cancel", {15'd0, tset_hold}, 16'd0);
`endif
        steps(3);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter shall be TIMEOUT, default 30; number of tset_tick strobes without a button press before edit auto-cancels.
REQ-002 Port shall be tset_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port shall be tset_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port shall be tset_en  input  1  single-cycle pulse; enter set mode, or cancel while editing.
REQ-005 Port shall be tset_up / tset_down  input  1 each  single-cycle pulses; increment or decrement the selected digit.
REQ-006 Port shall be tset_left / tset_right  input  1 each  single-cycle pulses; move the selection toward HR_1 or toward MIN_0.
REQ-007 Port shall be tset_confirm  input  1  single-cycle pulse; commit the edit buffer.
REQ-008 Port shall be tset_tick  input  1  single-cycle 1 Hz strobe; timeout timebase.
REQ-009 Port shall be tset_cur_time  input  16  live BCD time {HR_1,HR_0,MIN_1,MIN_0}.
REQ-010 Port shall be tset_hold  output  1  freeze request to the time counters.
REQ-011 Port shall be tset_sel  output  4  one-hot edited digit (bit3=HR_1 ... bit0=MIN_0); 0 when not editing.
REQ-012 Port shall be tset_disp  output  16  edit buffer, BCD, same layout as tset_cur_time.
REQ-013 Port shall be tset_load / tset_load_num  output  4 / 4  one-hot per-digit load strobe and the BCD value to load.

Function
REQ-014 The FSM shall have states IDLE, EDIT and COMMIT; tset_hold shall be 1 exactly in EDIT and COMMIT.
REQ-015 IDLE shall go to EDIT on tset_en: buffer <= tset_cur_time, tset_sel <= 4'b1000, timeout counter <= 0, with tset_hold high the next cycle.
REQ-016 Digit ranges shall be HR_1 0-2, HR_0 0-9 (0-3 when HR_1==2), MIN_1 0-5, MIN_0 0-9.
REQ-017 tset_up at the digit maximum shall wrap to 0, and tset_down at 0 shall wrap to the maximum; all arithmetic is 4-bit BCD and never yields a value outside the range.
REQ-018 When HR_1 becomes 2 while HR_0 > 3, HR_0 shall be clamped to 3 in the same cycle.
REQ-019 tset_left shall rotate the selection 0->1->2->3->0, and tset_right shall rotate it 3->2->1->0->3.
REQ-020 Simultaneous up+down, or simultaneous left+right, shall change nothing.
REQ-021 Priority in EDIT shall be tset_confirm > tset_en (cancel) > timeout > up/down/left/right.
REQ-022 Cancel (tset_en in EDIT) shall return to IDLE with no load strobes; tset_hold and tset_sel shall be 0 the next cycle.
REQ-023 tset_confirm in EDIT at cycle N shall go to COMMIT and assert tset_load 0001, 0010, 0100, 1000 in cycles N+1 through N+4, with tset_load_num equal to the matching buffer digit.
REQ-024 COMMIT shall return to IDLE after the fourth load, with tset_hold low at N+5; COMMIT ignores every button input.
REQ-025 tset_load shall be 0 in all cycles outside COMMIT.
REQ-026 tset_disp shall show the buffer in EDIT and COMMIT, and shall follow tset_cur_time in IDLE.
REQ-027 In IDLE, up/down/left/right/confirm shall be ignored.

Reset
REQ-028 While tset_rst is high: state IDLE, buffer 16'h0000, tset_sel 0, tset_load 0, tset_load_num 0, tset_hold 0, timeout counter 0.
REQ-029 Reset asserted in EDIT or COMMIT shall abort immediately; a partially issued commit sequence shall not resume.

Configuration
REQ-030 With macro TSET_TIMEOUT_EN defined, each tset_tick in EDIT shall increment the timeout counter, any button press shall clear it, and reaching TIMEOUT shall cancel exactly as in REQ-022.
REQ-031 With TSET_TIMEOUT_EN undefined, no timeout counter shall exist, tset_tick shall be ignored, and EDIT shall persist until confirm or cancel.

Verification
REQ-032 cur_time=16'h1259, en, confirm -> load 0001/0010/0100/1000 with num 9,5,2,1 on the next 4 cycles; hold low after.
REQ-033 buffer 16'h1900, sel HR_1, up -> disp 16'h2300 (clamp); up again -> 16'h0300.
REQ-034 sel MIN_1=0, down -> MIN_1=5; up+down in the same cycle -> unchanged.
REQ-035 EDIT, confirm+en in the same cycle -> commit sequence runs; en alone -> no loads, hold 0 the next cycle.
REQ-036 TSET_TIMEOUT_EN, TIMEOUT=3, 3 ticks with no buttons -> IDLE with no loads; a press after 2 ticks delays the cancel by 3 more ticks.
REQ-037 Reset asserted during the 2nd commit cycle -> all outputs 0 immediately; no further loads after release.
